// File: rtl/cfu_macc_sequencer.sv
// cfu_macc_sequencer: runs one dot-product job on the 4-way SIMD MAC CFU.
// Each job is clear, then per word set-input and MACC ACC0..3, then get ACC0..3.
// Define CFU_SEQ_OFFSET_EN to issue input/filter offset commands right after the clear.
module cfu_macc_sequencer #(
    parameter int ADDR_W = 12,
    parameter int K_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] start_in_base,
    input  logic [ADDR_W-1:0] start_flt_base,
    input  logic [ADDR_W-1:0] start_flt_stride,
    input  logic [K_W-1:0]    start_k,
`ifdef CFU_SEQ_OFFSET_EN
    input  logic [31:0]       start_in_off,
    input  logic [31:0]       start_flt_off,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              cfu_cmd_valid,
    input  logic              cfu_cmd_ready,
    output logic [9:0]        cfu_cmd_function_id,
    output logic [31:0]       cfu_cmd_inputs_0,
    output logic [31:0]       cfu_cmd_inputs_1,
    input  logic              cfu_rsp_valid,
    output logic              cfu_rsp_ready,
    input  logic [31:0]       cfu_rsp_outputs_0,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [127:0]      res_data,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, FETCH, DONE} state_t;
    typedef enum logic [2:0] {PH_CLR, PH_OFF_IN, PH_OFF_FLT, PH_SET, PH_MACC, PH_GET} phase_t;

    state_t            state;
    phase_t            phase, n_phase;
    logic [1:0]        r, n_r, r_inc;
    logic [K_W-1:0]    k, n_k, k_inc, k_len;
    logic [ADDR_W-1:0] in_base, flt_base, stride, n_addr;
    logic [6:0]        n_op;
    logic [31:0]       n_data;
    logic              n_fetch, n_done;
`ifdef CFU_SEQ_OFFSET_EN
    logic [31:0]       in_off, flt_off;
`endif

    assign cfu_cmd_inputs_1 = '0;
    assign r_inc = r + 2'd1;
    assign k_inc = k + K_W'(1);

    // next step of the command sequence once the current command's response arrives
    always_comb begin
        n_phase = phase;
        n_r = r;
        n_k = k;
        n_addr = '0;
        n_op = '0;
        n_data = '0;
        n_fetch = 1'b0;
        n_done = 1'b0;
        case (phase)
            PH_SET: begin
                n_phase = PH_MACC;
                n_r = 2'd0;
                n_fetch = 1'b1;
                n_addr = flt_base + ADDR_W'(k);
            end
            PH_MACC: begin
                if (r != 2'd3) begin
                    n_r = r_inc;
                    n_fetch = 1'b1;
                    n_addr = flt_base + ADDR_W'(r_inc) * stride + ADDR_W'(k);
                end else if (k_inc == k_len) begin
                    n_phase = PH_GET;
                    n_r = 2'd0;
                    n_k = k_inc;
                    n_op = 7'd11;
                end else begin
                    n_phase = PH_SET;
                    n_k = k_inc;
                    n_fetch = 1'b1;
                    n_addr = in_base + ADDR_W'(k_inc);
                end
            end
            PH_GET: begin
                if (r != 2'd3) begin
                    n_r = r_inc;
                    n_op = 7'd12 + 7'(r);
                end else begin
                    n_done = 1'b1;
                end
            end
`ifdef CFU_SEQ_OFFSET_EN
            PH_CLR: begin
                n_phase = PH_OFF_IN;
                n_op = 7'd2;
                n_data = in_off;
            end
            PH_OFF_IN: begin
                n_phase = PH_OFF_FLT;
                n_op = 7'd3;
                n_data = flt_off;
            end
`endif
            default: begin
                if (k_len == '0) begin
                    n_phase = PH_GET;
                    n_r = 2'd0;
                    n_op = 7'd11;
                end else begin
                    n_phase = PH_SET;
                    n_k = '0;
                    n_fetch = 1'b1;
                    n_addr = in_base;
                end
            end
        endcase
    end

    // control FSM with registered handshake outputs; one CFU command in flight at a time
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            phase <= PH_CLR;
            r <= '0;
            k <= '0;
            k_len <= '0;
            in_base <= '0;
            flt_base <= '0;
            stride <= '0;
`ifdef CFU_SEQ_OFFSET_EN
            in_off <= '0;
            flt_off <= '0;
`endif
            start_ready <= 1'b1;
            busy <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_rd_addr <= '0;
            cfu_cmd_valid <= 1'b0;
            cfu_cmd_function_id <= '0;
            cfu_cmd_inputs_0 <= '0;
            cfu_rsp_ready <= 1'b0;
            res_valid <= 1'b0;
            res_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        in_base <= start_in_base;
                        flt_base <= start_flt_base;
                        stride <= start_flt_stride;
                        k_len <= start_k;
`ifdef CFU_SEQ_OFFSET_EN
                        in_off <= start_in_off;
                        flt_off <= start_flt_off;
`endif
                        phase <= PH_CLR;
                        r <= '0;
                        k <= '0;
                        start_ready <= 1'b0;
                        busy <= 1'b1;
                        cfu_cmd_valid <= 1'b1;
                        cfu_cmd_function_id <= {7'd10, 3'b000};
                        cfu_cmd_inputs_0 <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cfu_cmd_ready) begin
                        cfu_cmd_valid <= 1'b0;
                        cfu_rsp_ready <= 1'b1;
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (cfu_rsp_valid) begin
                        cfu_rsp_ready <= 1'b0;
                        if (phase == PH_GET)
                            res_data[32*r +: 32] <= cfu_rsp_outputs_0;
                        phase <= n_phase;
                        r <= n_r;
                        k <= n_k;
                        if (n_done) begin
                            res_valid <= 1'b1;
                            state <= DONE;
                        end else if (n_fetch) begin
                            mem_rd_en <= 1'b1;
                            mem_rd_addr <= n_addr;
                            state <= FETCH;
                        end else begin
                            cfu_cmd_valid <= 1'b1;
                            cfu_cmd_function_id <= {n_op, 3'b000};
                            cfu_cmd_inputs_0 <= n_data;
                            state <= ISSUE;
                        end
                    end
                end
                FETCH: begin
                    if (mem_rd_en) begin
                        mem_rd_en <= 1'b0;
                    end else begin
                        cfu_cmd_valid <= 1'b1;
                        cfu_cmd_function_id <= {((phase == PH_SET) ? 7'd5 : 7'd6 + 7'(r)), 3'b000};
                        cfu_cmd_inputs_0 <= mem_rd_data;
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        start_ready <= 1'b1;
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfu_macc_sequencer.sv
// tb_cfu_macc_sequencer: scoreboard bench with a behavioural buffer and SIMD MAC CFU model
module tb_cfu_macc_sequencer;
    localparam int AW = 4;
    localparam int KW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_valid, start_ready;
    logic [AW-1:0] start_in_base, start_flt_base, start_flt_stride;
    logic [KW-1:0] start_k;
`ifdef CFU_SEQ_OFFSET_EN
    logic [31:0]   start_in_off, start_flt_off;
`endif
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic          cfu_cmd_valid, cfu_cmd_ready;
    logic [9:0]    cfu_cmd_function_id;
    logic [31:0]   cfu_cmd_inputs_0, cfu_cmd_inputs_1;
    logic          cfu_rsp_valid, cfu_rsp_ready;
    logic [31:0]   cfu_rsp_outputs_0;
    logic          res_valid, res_ready;
    logic [127:0]  res_data;
    logic          busy;

    int total = 0;
    int bad = 0;
    int proto_err = 0;
    logic [31:0]   mem [0:15];
    logic [38:0]   cmd_log[$], exp_cmd[$];
    logic [AW-1:0] rd_log[$], exp_rd[$];
    logic [127:0]  res_q[$];

    logic [31:0]   c_acc [0:3];
    logic [31:0]   c_in, m_rsp;
    int            c_ioff, c_foff;
    logic [6:0]    m_op;
    logic          pend_stall;
    logic [41:0]   pend_payload;

    always #5 clk = ~clk;

    cfu_macc_sequencer #(.ADDR_W(AW), .K_W(KW)) dut (
        .clk(clk),
        .reset(reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_in_base(start_in_base),
        .start_flt_base(start_flt_base),
        .start_flt_stride(start_flt_stride),
        .start_k(start_k),
`ifdef CFU_SEQ_OFFSET_EN
        .start_in_off(start_in_off),
        .start_flt_off(start_flt_off),
`endif
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .cfu_cmd_valid(cfu_cmd_valid),
        .cfu_cmd_ready(cfu_cmd_ready),
        .cfu_cmd_function_id(cfu_cmd_function_id),
        .cfu_cmd_inputs_0(cfu_cmd_inputs_0),
        .cfu_cmd_inputs_1(cfu_cmd_inputs_1),
        .cfu_rsp_valid(cfu_rsp_valid),
        .cfu_rsp_ready(cfu_rsp_ready),
        .cfu_rsp_outputs_0(cfu_rsp_outputs_0),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .busy(busy)
    );

    function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b, input int ao, input int bo);
        int s = 0;
        for (int i = 0; i < 4; i++)
            s += (int'($signed(a[i*8 +: 8])) + ao) * (int'($signed(b[i*8 +: 8])) + bo);
        return s;
    endfunction

    // word buffer: data one cycle after the read strobe, every read address logged
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            rd_log.push_back(mem_rd_addr);
        end
    end

    // CFU model: answers the cycle after accept, logs commands, flags protocol breaches
    always @(posedge clk) begin
        if (reset) begin
            cfu_rsp_valid <= 1'b0;
            cfu_rsp_outputs_0 <= '0;
            for (int i = 0; i < 4; i++) c_acc[i] = '0;
            c_in = '0;
            c_ioff = 0;
            c_foff = 0;
            pend_stall = 1'b0;
        end else begin
            if (pend_stall && (!cfu_cmd_valid || {cfu_cmd_function_id, cfu_cmd_inputs_0} != pend_payload))
                proto_err++;
            pend_stall = cfu_cmd_valid && !cfu_cmd_ready;
            pend_payload = {cfu_cmd_function_id, cfu_cmd_inputs_0};
            if (cfu_rsp_valid && cfu_rsp_ready) cfu_rsp_valid <= 1'b0;
            if (cfu_cmd_valid && cfu_cmd_ready) begin
                if (cfu_rsp_valid || cfu_cmd_function_id[2:0] != 3'd0 || cfu_cmd_inputs_1 != 32'd0)
                    proto_err++;
                m_op = cfu_cmd_function_id[9:3];
                m_rsp = '0;
                cmd_log.push_back({m_op, cfu_cmd_inputs_0});
                if (m_op == 7'd10) for (int i = 0; i < 4; i++) c_acc[i] = '0;
                else if (m_op == 7'd2) c_ioff = cfu_cmd_inputs_0;
                else if (m_op == 7'd3) c_foff = cfu_cmd_inputs_0;
                else if (m_op == 7'd5) c_in = cfu_cmd_inputs_0;
                else if (m_op >= 7'd6 && m_op <= 7'd9)
                    c_acc[2'(m_op - 7'd6)] = c_acc[2'(m_op - 7'd6)] + dot(c_in, cfu_cmd_inputs_0, c_ioff, c_foff);
                else if (m_op >= 7'd11 && m_op <= 7'd14) m_rsp = c_acc[2'(m_op - 7'd11)];
                cfu_rsp_valid <= 1'b1;
                cfu_rsp_outputs_0 <= m_rsp;
            end
        end
    end

    task automatic start_job(input logic [AW-1:0] ib, input logic [AW-1:0] fb, input logic [AW-1:0] st,
                             input int k, input int io, input int fo, output logic [127:0] res);
        logic [31:0]   acc [0:3];
        logic [AW-1:0] a, b;
        for (int r = 0; r < 4; r++) acc[r] = '0;
        exp_cmd.push_back({7'd10, 32'd0});
`ifdef CFU_SEQ_OFFSET_EN
        exp_cmd.push_back({7'd2, 32'(io)});
        exp_cmd.push_back({7'd3, 32'(fo)});
`endif
        for (int kk = 0; kk < k; kk++) begin
            a = AW'(int'(ib) + kk);
            exp_rd.push_back(a);
            exp_cmd.push_back({7'd5, mem[a]});
            for (int r = 0; r < 4; r++) begin
                b = AW'(int'(fb) + r * int'(st) + kk);
                exp_rd.push_back(b);
                exp_cmd.push_back({7'(6 + r), mem[b]});
                acc[r] = acc[r] + dot(mem[a], mem[b], io, fo);
            end
        end
        for (int r = 0; r < 4; r++) exp_cmd.push_back({7'(11 + r), 32'd0});
        res = {acc[3], acc[2], acc[1], acc[0]};
        total++;
        if (start_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_ready_idle: got %b want 1", start_ready);
        end
        start_in_base = ib;
        start_flt_base = fb;
        start_flt_stride = st;
        start_k = KW'(k);
`ifdef CFU_SEQ_OFFSET_EN
        start_in_off = io;
        start_flt_off = fo;
`endif
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        total++;
        if ({cfu_cmd_valid, cfu_cmd_function_id} !== {1'b1, 10'd80}) begin
            bad++;
            $display("FAIL first_cmd: got valid=%b fid=%0d want valid=1 fid=80", cfu_cmd_valid, cfu_cmd_function_id);
        end
        total++;
        if ({busy, start_ready} !== 2'b10) begin
            bad++;
            $display("FAIL busy_after_start: got busy=%b start_ready=%b want 1 0", busy, start_ready);
        end
    endtask

    task automatic check_logs(input string name);
        int idx = -1;
        total++;
        if (cmd_log.size() != exp_cmd.size()) begin
            bad++;
            $display("FAIL %s cmd_count: got %0d want %0d", name, cmd_log.size(), exp_cmd.size());
        end else begin
            foreach (exp_cmd[i]) if (idx < 0 && cmd_log[i] !== exp_cmd[i]) idx = i;
            if (idx >= 0) begin
                bad++;
                $display("FAIL %s cmd[%0d]: got %h want %h", name, idx, cmd_log[idx], exp_cmd[idx]);
            end
        end
        idx = -1;
        total++;
        if (rd_log.size() != exp_rd.size()) begin
            bad++;
            $display("FAIL %s rd_count: got %0d want %0d", name, rd_log.size(), exp_rd.size());
        end else begin
            foreach (exp_rd[i]) if (idx < 0 && rd_log[i] !== exp_rd[i]) idx = i;
            if (idx >= 0) begin
                bad++;
                $display("FAIL %s rd[%0d]: got %0d want %0d", name, idx, rd_log[idx], exp_rd[idx]);
            end
        end
        total++;
        if (proto_err !== 0) begin
            bad++;
            $display("FAIL %s protocol: got %0d errors want 0", name, proto_err);
        end
        cmd_log.delete();
        exp_cmd.delete();
        rd_log.delete();
        exp_rd.delete();
    endtask

    task automatic wait_finish(input string name);
        logic [127:0] exp;
        int n = 0;
        while (!res_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!res_valid || res_q.size() == 0) begin
            bad++;
            $display("FAIL %s result_timeout: got res_valid=%b want 1", name, res_valid);
            res_q.delete();
        end else begin
            exp = res_q.pop_front();
            if (res_data !== exp) begin
                bad++;
                $display("FAIL %s res_data: got %h want %h", name, res_data, exp);
            end
            @(negedge clk);
            total++;
            if ({res_valid, start_ready, busy} !== 3'b010) begin
                bad++;
                $display("FAIL %s back_to_idle: got %b want 010", name, {res_valid, start_ready, busy});
            end
        end
        check_logs(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({start_ready, busy, mem_rd_en, cfu_cmd_valid, cfu_rsp_ready, res_valid} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 100000", {start_ready, busy, mem_rd_en, cfu_cmd_valid, cfu_rsp_ready, res_valid});
        end
        total++;
        if ({mem_rd_addr, cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1} !== '0) begin
            bad++;
            $display("FAIL reset_payload: got addr=%0d fid=%0d in0=%h in1=%h want 0", mem_rd_addr, cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1);
        end
        total++;
        if (res_data !== '0) begin
            bad++;
            $display("FAIL reset_res: got %h want 0", res_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [127:0] res;
        mem[0] = 32'h01010101;
        mem[1] = 32'h01010101;
        mem[2] = 32'h02020202;
        mem[3] = 32'hFFFFFFFF;
        mem[4] = 32'h00000000;
        start_job(4'd0, 4'd1, 4'd1, 1, 0, 0, res);
        res_q.push_back(128'h00000000_FFFFFFFC_00000008_00000004);
        wait_finish("basic");
    endtask

    task automatic test_k0();
        logic [127:0] res;
        start_job(4'd3, 4'd5, 4'd2, 0, 0, 0, res);
        res_q.push_back(128'd0);
        wait_finish("k0");
    endtask

    task automatic test_stall();
        logic [127:0] res;
        logic [41:0]  snap;
        int n = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        res_ready = 1'b0;
        start_job(4'd5, 4'd7, 4'd2, 2, 0, 0, res);
        res_q.push_back(res);
        while (!(cfu_cmd_valid && cfu_cmd_function_id == 10'd48) && n < 200) begin
            @(negedge clk);
            n++;
        end
        cfu_cmd_ready = 1'b0;
        snap = {cfu_cmd_function_id, cfu_cmd_inputs_0};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({cfu_cmd_valid, start_ready, cfu_cmd_function_id, cfu_cmd_inputs_0} !== {2'b10, snap}) begin
                bad++;
                $display("FAIL stall_cmd cycle %0d: got v=%b sr=%b fid=%0d in0=%h want v=1 sr=0 %h", c, cfu_cmd_valid, start_ready, cfu_cmd_function_id, cfu_cmd_inputs_0, snap);
            end
        end
        cfu_cmd_ready = 1'b1;
        n = 0;
        while (!res_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        snap[31:0] = res_data[31:0];
        res = res_data;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({res_valid, start_ready} !== 2'b10 || res_data !== res) begin
                bad++;
                $display("FAIL stall_done cycle %0d: got v=%b sr=%b data=%h want v=1 sr=0 data=%h", c, res_valid, start_ready, res_data, res);
            end
        end
        res_ready = 1'b1;
        wait_finish("stall");
    endtask

    task automatic test_wrap();
        logic [127:0] res;
        int lit [15] = '{14, 0, 3, 6, 9, 15, 1, 4, 7, 10, 0, 2, 5, 8, 11};
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        start_job(4'd14, 4'd0, 4'd3, 3, 0, 0, res);
        res_q.push_back(res);
        exp_rd.delete();
        foreach (lit[i]) exp_rd.push_back(AW'(lit[i]));
        wait_finish("wrap");
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int n = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        start_job(4'd2, 4'd6, 4'd1, 2, 0, 0, res);
        while (!(cfu_rsp_ready && cmd_log.size() > 0 && cmd_log[cmd_log.size()-1][38:32] == 7'd7) && n < 200) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({cfu_cmd_valid, res_valid, mem_rd_en, cfu_rsp_ready, start_ready, busy} !== 6'b000010) begin
            bad++;
            $display("FAIL reset_mid: got %b want 000010", {cfu_cmd_valid, res_valid, mem_rd_en, cfu_rsp_ready, start_ready, busy});
        end
        cmd_log.delete();
        exp_cmd.delete();
        rd_log.delete();
        exp_rd.delete();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        start_job(4'd9, 4'd1, 4'd4, 1, 0, 0, res);
        res_q.push_back(res);
        wait_finish("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [127:0] res;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            start_job(AW'($urandom), AW'($urandom), AW'($urandom), int'($urandom_range(1, 3)), 0, 0, res);
            res_q.push_back(res);
            wait_finish("b2b");
        end
    endtask

`ifdef CFU_SEQ_OFFSET_EN
    task automatic test_offset();
        logic [127:0] res;
        mem[0] = 32'h80808080;
        for (int i = 1; i < 5; i++) mem[i] = 32'h01010101;
        start_job(4'd0, 4'd1, 4'd1, 1, 128, 0, res);
        res_q.push_back(128'd0);
        wait_finish("offset");
    endtask
`endif

    initial begin
        start_valid = 1'b0;
        start_in_base = '0;
        start_flt_base = '0;
        start_flt_stride = '0;
        start_k = '0;
`ifdef CFU_SEQ_OFFSET_EN
        start_in_off = '0;
        start_flt_off = '0;
`endif
        cfu_cmd_ready = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_k0();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
`ifdef CFU_SEQ_OFFSET_EN
        test_offset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cfu_macc_sequencer.md
# cfu_macc_sequencer

Job-level controller that drives the 4-way SIMD MAC CFU through its command/response handshake, so software no longer issues each CFU instruction by hand. Given an input-vector base, a filter base, a row stride and a length K in 32-bit words, it fetches operands from a local word-addressed buffer. It then issues the full sequence: clear, then per word set-global-input and MACC ACC0..3, then get ACC0..3. The four accumulator results are returned as one packed result beat.

## Interface
- ADDR_W, 12, buffer word-address width; all address arithmetic is modulo 2^ADDR_W
- K_W, 12, width of the job length K

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start_valid  in  1  job request
- start_ready  out  1  high only in IDLE
- start_in_base  in  ADDR_W  input-vector base word address
- start_flt_base  in  ADDR_W  filter row 0 base
- start_flt_stride  in  ADDR_W  word distance between filter rows
- start_k  in  K_W  words per row; 0 is legal
- mem_rd_en  out  1  buffer read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  32  data, valid exactly 1 cycle after mem_rd_en
- cfu_cmd_valid  out  1  CFU command valid
- cfu_cmd_ready  in  1  CFU command ready
- cfu_cmd_function_id  out  10  opcode in [9:3], [2:0]=0
- cfu_cmd_inputs_0  out  32  operand
- cfu_cmd_inputs_1  out  32  always 0
- cfu_rsp_valid  in  1  CFU response valid
- cfu_rsp_ready  out  1  high only in WAIT_RSP
- cfu_rsp_outputs_0  in  32  CFU response data
- res_valid  out  1  result beat valid
- res_ready  in  1  result consumer ready
- res_data  out  128  {acc3, acc2, acc1, acc0}, acc0 in [31:0]
- busy  out  1  high in every state except IDLE

## Operation
- Opcodes used: 10 clear, 5 set global input, 6+r MACC ACCr, 11+r get ACCr. Optional opcodes 2 and 3 are used only with the configuration macro.
- States: IDLE, ISSUE, WAIT_RSP, FETCH, DONE.
- IDLE: on start_valid, latch the job fields, set k=0 and r=0, then go to ISSUE(clear).
- Command order: clear; for k=0..K-1: FETCH input[in_base+k] -> ISSUE op5(data); for r=0..3: FETCH filter[flt_base + r*flt_stride + k] -> ISSUE op(6+r)(data); then ISSUE op11..op14.
- FETCH: assert mem_rd_en for one cycle, capture mem_rd_data the next cycle into the operand register, then go to ISSUE.
- ISSUE: hold cfu_cmd_valid with a stable payload until cfu_cmd_ready. Then go to WAIT_RSP.
- WAIT_RSP: hold cfu_rsp_ready high. On cfu_rsp_valid, consume the response. Get responses store into result slot r. Then advance the sequence.
- At most one CFU command is outstanding at any time.
- K=0: exactly 5 commands (clear, get×4); res_data = 0.
- After op14 returns, go to DONE: res_valid=1 and res_data stable until res_ready, then go to IDLE.
- Filter address is computed as flt_base + r*flt_stride + k, truncated to ADDR_W. The product r*flt_stride is truncated too.
- Results are the CFU's own 32-bit wrapped sums; no saturation.
- Reset mid-job: the next cycle is IDLE, all valids are 0, and the job is dropped. The system resets the CFU with the same reset.

## Timing
- Reset values: start_ready=1, busy=0, mem_rd_en=0, mem_rd_addr=0, cfu_cmd_valid=0, cfu_cmd_function_id=0, cfu_cmd_inputs_0/1=0, cfu_rsp_ready=0, res_valid=0, res_data=0.
- start is accepted on a cycle with start_valid && start_ready. cfu_cmd_valid first rises the following cycle.
- Each FETCH takes 2 cycles. Each command takes at least 2 cycles against a CFU that responds the cycle after accept.
- Commands per job: 1 + 5K + 4, plus 2 with the macro.
- A new start is accepted only in IDLE; start_ready is 0 during DONE.
- cfu_cmd_valid is never deasserted before acceptance.

## Configuration
- CFU_SEQ_OFFSET_EN defined: adds ports start_in_off[31:0] and start_flt_off[31:0], latched at start. Op2(in_off) then op3(flt_off) are issued immediately after clear.
- CFU_SEQ_OFFSET_EN undefined: the ports are absent, no offset commands are issued, and the CFU offsets are left untouched.

## Test plan
- K=1, input 0x01010101, rows 0x01010101 / 0x02020202 / 0xFFFFFFFF / 0x00000000, offsets 0 -> res_data {0x00000000, 0xFFFFFFFC, 0x00000008, 0x00000004}, 10 commands in order.
- K=0 -> exactly op10, op11, op12, op13, op14 are issued; res_data = 0; no mem_rd_en.
- cfu_cmd_ready low 3 cycles during a MACC, res_ready low 5 cycles in DONE -> payload/res_data stable, no duplicated command, start_ready=0 throughout.
- ADDR_W=4, in_base=14, K=3, flt_base=0, stride=3 -> input reads 14, 15, 0; row 3 reads 9, 10, 11.
- reset asserted while in WAIT_RSP of a MACC -> next cycle all valids 0, start_ready=1; a following K=1 job gives correct results.
- With CFU_SEQ_OFFSET_EN, in_off=128, flt_off=0, K=1, input 0x80808080, rows all 0x01010101 -> each acc = 0, op2/op3 issued after op10.
